// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Optional stall watchdog that revokes a silent grant: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 5000000,
  localparam int GRANT_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy,
  output logic                      timeout_evt
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [GRANT_W-1:0]  last_grant;
  logic [GRANT_W-1:0]  winner;
  logic [GRANT_W-1:0]  cand;
  logic                found;
  logic                any_req;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_valid;
  logic                sel_last;
  logic                fire;
  logic                last_fire;
  logic                timeout_hit;

  assign any_req = |req_valid;

  // Search starts one past the previous holder so every requester gets a turn.
  always_comb begin : rr_pick
    winner = last_grant;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GRANT_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin : grant_mux
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GRANT_W'(i) == grant_id) begin
        sel_data  = req_data[i*DATA_W +: DATA_W];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  assign fire      = (state == XFER) && sel_valid && tx_ready;
  assign last_fire = fire && sel_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GRANT_W'(NUM_REQ - 1);
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        grant_id <= winner;
      end
      if (state == XFER && (last_fire || timeout_hit)) begin
        last_grant <= grant_id;
      end
    end
  end

  // Data path is a pure pass-through while locked so uart_tx sees no extra latency.
  always_comb begin : fsm_comb
    state_next = state;
    busy       = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = XFER;
        end
      end
      XFER: begin
        busy     = 1'b1;
        tx_valid = sel_valid;
        tx_data  = sel_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (GRANT_W'(i) == grant_id) && tx_ready;
        end
        if (last_fire || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_q;

  // Only a missing requester byte counts; uart_tx backpressure never trips the watchdog.
  assign timeout_hit = (state == XFER) && !sel_valid && (stall_cnt == STALL_LIMIT);
  assign timeout_evt = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state != XFER || fire || timeout_hit) begin
        stall_cnt <= '0;
      end else if (!sel_valid) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_evt = 1'b0;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed test-plan scenarios followed by
// randomized packet traffic against a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ        = 2;
  localparam int DATA_W         = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int GRANT_W        = 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                last;
    int                gap;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [GRANT_W-1:0]        grant_id;
  logic                      busy;
  logic                      timeout_evt;

  beat_t             src_q[NUM_REQ][$];
  logic [DATA_W-1:0] exp_q[NUM_REQ][$];
  logic [DATA_W-1:0] tx_log[$];
  logic [DATA_W-1:0] exp_log[$];
  int                gap_left[NUM_REQ];
  logic [NUM_REQ-1:0] hs;
  int                ready_prob;
  bit                gen_en;

  int m_owner;
  int m_last;
  int m_grant;
  int m_stall;
  bit m_tmo;

  int compare_count;
  int mismatch_count;
  int tmo_pulses;

  always #10 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compare_count++;
    assert (obs === exp_v) else begin
      mismatch_count++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_beat(input int r, input logic [DATA_W-1:0] d, input bit last, input int gap);
    beat_t b;
    b.data = d;
    b.last = last;
    b.gap  = gap;
    if (src_q[r].size() == 0 && !req_valid[r]) gap_left[r] = gap;
    src_q[r].push_back(b);
    exp_q[r].push_back(d);
  endtask

  task automatic push_random_packet(input int r);
    int len;
    len = $urandom_range(1, 4);
    for (int k = 0; k < len; k++) begin
      push_beat(r, DATA_W'($urandom), (k == len - 1), $urandom_range(0, 3));
    end
  endtask

  task automatic reset_state();
    for (int r = 0; r < NUM_REQ; r++) begin
      src_q[r].delete();
      exp_q[r].delete();
      gap_left[r] = 0;
    end
    tx_log.delete();
    exp_log.delete();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    hs        = '0;
    m_owner   = -1;
    m_last    = NUM_REQ - 1;
    m_grant   = 0;
    m_stall   = 0;
    m_tmo     = 1'b0;
  endtask

  // Requesters: present queued beats after their gap, hold until handshake.
  task automatic applyStimulus();
    for (int r = 0; r < NUM_REQ; r++) begin
      if (hs[r]) begin
        void'(src_q[r].pop_front());
        req_valid[r] = 1'b0;
        if (src_q[r].size() > 0) gap_left[r] = src_q[r][0].gap;
      end
      if (gen_en && src_q[r].size() == 0 && !req_valid[r] && $urandom_range(0, 3) == 0) begin
        push_random_packet(r);
      end
      if (!req_valid[r] && src_q[r].size() > 0) begin
        if (gap_left[r] == 0) begin
          req_valid[r] = 1'b1;
          req_data[r*DATA_W +: DATA_W] = src_q[r][0].data;
          req_last[r] = src_q[r][0].last;
        end else begin
          gap_left[r]--;
        end
      end
      if (!req_valid[r]) begin
        req_data[r*DATA_W +: DATA_W] = DATA_W'($urandom);
        req_last[r] = 1'($urandom);
      end
    end
    hs = '0;
    tx_ready = ($urandom_range(0, 99) < ready_prob);
  endtask

  // Reference model: packet-granular round robin with a one-cycle arbitration bubble.
  task automatic model_step();
    int o;
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      if (|req_valid) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (m_owner < 0 && req_valid[(m_last + k) % NUM_REQ]) m_owner = (m_last + k) % NUM_REQ;
        end
        m_grant = m_owner;
        m_stall = 0;
      end
    end else begin
      o = m_owner;
      if (req_valid[o] && tx_ready) begin
        check_eq("sb_pending", (exp_q[o].size() != 0), 1);
        if (exp_q[o].size() != 0) check_eq("sb_byte", tx_data, exp_q[o].pop_front());
        m_stall = 0;
        if (req_last[o]) begin
          m_last  = o;
          m_owner = -1;
        end
      end else if (!req_valid[o]) begin
        m_stall++;
`ifdef UART_ARB_TIMEOUT_EN
        if (m_stall == TIMEOUT_CYCLES) begin
          m_last  = o;
          m_owner = -1;
          m_tmo   = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic checkOutput();
    logic [NUM_REQ-1:0] ready_exp;
    check_eq("busy", busy, (m_owner >= 0));
    check_eq("timeout_evt", timeout_evt, m_tmo);
    if (m_owner < 0) begin
      check_eq("idle_tx_valid", tx_valid, 0);
      check_eq("idle_req_ready", req_ready, 0);
      check_eq("idle_grant_id", grant_id, m_grant);
    end else begin
      ready_exp = '0;
      ready_exp[m_owner] = tx_ready;
      check_eq("tx_valid", tx_valid, req_valid[m_owner]);
      check_eq("tx_data", tx_data, req_data[m_owner*DATA_W +: DATA_W]);
      check_eq("req_ready", req_ready, ready_exp);
      check_eq("grant_id", grant_id, m_owner);
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_log.push_back(tx_data);
    if (timeout_evt === 1'b1) tmo_pulses++;
    hs = req_valid & req_ready;
    model_step();
  endtask

  task automatic step_cycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_state();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, tx_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < tx_log.size()) check_eq($sformatf("%s[%0d]", tag, i), tx_log[i], exp_log[i]);
    end
    exp_log.delete();
  endtask

  function automatic bit all_drained();
    bit done;
    done = (m_owner < 0);
    for (int r = 0; r < NUM_REQ; r++) begin
      if (src_q[r].size() != 0 || req_valid[r]) done = 1'b0;
    end
    return done;
  endfunction

  initial begin
    bit drained;
    compare_count  = 0;
    mismatch_count = 0;
    tmo_pulses     = 0;
    gen_en         = 1'b0;
    ready_prob     = 100;
    tx_ready       = 1'b0;
    rst_n          = 1'b0;
    reset_state();

    // Reset values while rst_n is held low.
    #25;
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_timeout_evt", timeout_evt, 0);

    // Multi-byte packet from req0 blocks req1 until its last byte.
    do_reset();
    push_beat(0, 8'h41, 1'b0, 0);
    push_beat(0, 8'h42, 1'b0, 0);
    push_beat(0, 8'h43, 1'b1, 0);
    push_beat(1, 8'h55, 1'b1, 0);
    applyStimulus();
    run_cycles(10);
    exp_log.push_back(8'h41);
    exp_log.push_back(8'h42);
    exp_log.push_back(8'h43);
    exp_log.push_back(8'h55);
    check_log("tp1_seq");

    // Continuous single-byte packets alternate, req0 first.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_beat(0, 8'hA0, 1'b1, 0);
      push_beat(1, 8'hB1, 1'b1, 0);
    end
    applyStimulus();
    run_cycles(20);
    for (int k = 0; k < 4; k++) begin
      exp_log.push_back(8'hA0);
      exp_log.push_back(8'hB1);
    end
    check_log("tp2_alt");

    // uart_tx backpressure for 20 cycles, then exactly one transfer.
    do_reset();
    ready_prob = 0;
    push_beat(0, 8'h10, 1'b1, 0);
    applyStimulus();
    run_cycles(20);
    ready_prob = 100;
    step_cycle();
    check_eq("tp3_no_xfer_len", tx_log.size(), 0);
    run_cycles(4);
    exp_log.push_back(8'h10);
    check_log("tp3_one");

    // Mid-packet gap on req1 keeps the lock while req0 waits.
    do_reset();
    push_beat(1, 8'h01, 1'b0, 0);
    push_beat(1, 8'h02, 1'b1, 5);
    push_beat(0, 8'hC0, 1'b1, 3);
    applyStimulus();
    run_cycles(16);
    exp_log.push_back(8'h01);
    exp_log.push_back(8'h02);
    exp_log.push_back(8'hC0);
    check_log("tp4_gap");

    // Stalled grant: watchdog revokes it with the macro, lock holds without it.
    do_reset();
    tmo_pulses = 0;
    push_beat(0, 8'h31, 1'b0, 0);
    push_beat(1, 8'h77, 1'b1, 0);
    applyStimulus();
`ifdef UART_ARB_TIMEOUT_EN
    run_cycles(30);
    check_eq("tp6_pulses", tmo_pulses, 1);
    exp_log.push_back(8'h31);
    exp_log.push_back(8'h77);
    check_log("tp6_revoke");
`else
    run_cycles(40);
    check_eq("tp6_pulses", tmo_pulses, 0);
    check_eq("tp6_req1_ready", req_ready[1], 0);
    check_eq("tp6_busy", busy, 1);
    exp_log.push_back(8'h31);
    check_log("tp6_locked");
`endif

    // Asynchronous reset mid-packet, then req0 wins again.
    do_reset();
    push_beat(0, 8'hC1, 1'b0, 0);
    push_beat(0, 8'hC2, 1'b0, 0);
    push_beat(0, 8'hC3, 1'b1, 0);
    push_beat(1, 8'hD1, 1'b1, 0);
    applyStimulus();
    run_cycles(2);
    exp_log.push_back(8'hC1);
    check_log("tp5_partial");
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("tp5_rst_busy", busy, 0);
    check_eq("tp5_rst_tx_valid", tx_valid, 0);
    check_eq("tp5_rst_req_ready", req_ready, 0);
    check_eq("tp5_rst_grant_id", grant_id, 0);
    check_eq("tp5_rst_timeout_evt", timeout_evt, 0);
    reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_beat(0, 8'hE0, 1'b1, 0);
    push_beat(1, 8'hE1, 1'b1, 0);
    applyStimulus();
    run_cycles(8);
    exp_log.push_back(8'hE0);
    exp_log.push_back(8'hE1);
    check_log("tp5_after");

    // Randomized traffic with random uart_tx backpressure.
    do_reset();
    ready_prob = 70;
    gen_en     = 1'b1;
    applyStimulus();
    run_cycles(800);
    gen_en  = 1'b0;
    drained = all_drained();
    for (int i = 0; i < 600 && !drained; i++) begin
      step_cycle();
      drained = all_drained();
    end
    check_eq("rand_drained", drained, 1);
    for (int r = 0; r < NUM_REQ; r++) begin
      check_eq($sformatf("rand_leftover%0d", r), exp_q[r].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
